// File: rtl/seq_multiplier_sm.sv
// Iterative shift-add multiplier: one partial-product step per clock, N steps per product.
// Supports signed or unsigned operands per operation, with a start/busy/done handshake and synchronous abort.
module seq_multiplier_sm #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic             abort,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   r
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [N:0]       acc, acc_n;
    logic [N-1:0]     mq, mq_n;
    logic [N-1:0]     mc, mc_n;
    logic             mode, mode_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [2*N-1:0]   r_n;
    logic             done_n;

    logic [N:0]       ext_m, addend, sum, acc_sh;
    logic [N-1:0]     q_sh;
    logic             last_step;

    // The final step of a signed product subtracts the multiplicand: the multiplier MSB weighs -2^(N-1).
    assign last_step = (cnt == CW'(1));
    assign ext_m     = mode ? {mc[N-1], mc} : {1'b0, mc};
    assign addend    = !mq[0] ? '0 : (mode && last_step) ? (~ext_m + (N+1)'(1)) : ext_m;
    assign sum       = acc + addend;
    assign acc_sh    = {mode & sum[N], sum[N:1]};
    assign q_sh      = {sum[0], mq[N-1:1]};
    assign busy      = (state == RUN);

    // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        mq_n    = mq;
        mc_n    = mc;
        mode_n  = mode;
        cnt_n   = cnt;
        r_n     = r;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    mc_n    = a;
                    mq_n    = b;
                    mode_n  = signed_mode;
                    acc_n   = '0;
                    cnt_n   = CW'(N);
                    state_n = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    acc_n = acc_sh;
                    mq_n  = q_sh;
                    cnt_n = cnt - CW'(1);
                    if (last_step) begin
                        r_n     = {acc_sh[N-1:0], q_sh};
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            mq    <= '0;
            mc    <= '0;
            mode  <= 1'b0;
            cnt   <= '0;
            r     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            mq    <= mq_n;
            mc    <= mc_n;
            mode  <= mode_n;
            cnt   <= cnt_n;
            r     <= r_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_seq_multiplier_sm.sv
// Self-checking bench for seq_multiplier_sm: N=4 and N=8 instances.
// Expected products are pushed to a scoreboard queue at launch and compared on each done pulse.
module tb_seq_multiplier_sm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start4, sm4, abort4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  r4;
    logic        start8, sm8, abort8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] r8;

    int checks = 0;
    int errors = 0;
    logic [7:0]  q4[$];
    logic [15:0] q8[$];

    seq_multiplier_sm #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4), .abort(abort4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .r(r4));

    seq_multiplier_sm #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8), .abort(abort8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .r(r8));

    // Behavioural product of w-bit operands, truncated to 2w bits.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input int w, input bit s);
        int x, y, p;
        x = int'(a);
        y = int'(b);
        if (s && a[w-1]) x = x - (1 << w);
        if (s && b[w-1]) y = y - (1 << w);
        p = x * y;
        return 16'(p & ((1 << (2 * w)) - 1));
    endfunction

    always @(negedge clk) begin
        if (rst_n && done4) begin
            logic [7:0] e;
            checks++;
            if (busy4) begin
                errors++;
                $display("FAIL sb4_busy_with_done: busy=%0b required 0", busy4);
            end
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL sb4_unexpected_done: r=%h with no expected product", r4);
            end else begin
                e = q4.pop_front();
                if (r4 !== e) begin
                    errors++;
                    $display("FAIL sb4_product: r=%h required %h", r4, e);
                end
            end
        end
        if (rst_n && done8) begin
            logic [15:0] e;
            checks++;
            if (busy8) begin
                errors++;
                $display("FAIL sb8_busy_with_done: busy=%0b required 0", busy8);
            end
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL sb8_unexpected_done: r=%h with no expected product", r8);
            end else begin
                e = q8.pop_front();
                if (r8 !== e) begin
                    errors++;
                    $display("FAIL sb8_product: r=%h required %h", r8, e);
                end
            end
        end
    end

    task automatic launch4(input logic [3:0] a, input logic [3:0] b, input bit s, input bit push);
        a4 = a; b4 = b; sm4 = s; start4 = 1'b1;
        if (push) q4.push_back(8'(model({4'b0, a}, {4'b0, b}, 4, s)));
    endtask

    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input bit s, input bit push);
        a8 = a; b8 = b; sm8 = s; start8 = 1'b1;
        if (push) q8.push_back(model(a, b, 8, s));
    endtask

    task automatic wait_done4(output int cycles, output int busy_cycles);
        cycles = 0; busy_cycles = 0;
        do begin
            @(negedge clk);
            start4 = 1'b0;
            cycles++;
            if (busy4) busy_cycles++;
        end while (!done4 && cycles < 20);
    endtask

    task automatic wait_done8(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            start8 = 1'b0;
            cycles++;
        end while (!done8 && cycles < 30);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start4 = 0; sm4 = 0; abort4 = 0; a4 = 0; b4 = 0;
        start8 = 0; sm8 = 0; abort8 = 0; a8 = 0; b8 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy4, done4, r4} !== 10'b0) begin
            errors++;
            $display("FAIL reset4: busy=%b done=%b r=%h required 0 0 00", busy4, done4, r4);
        end
        checks++;
        if ({busy8, done8, r8} !== 18'b0) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b r=%h required 0 0 0000", busy8, done8, r8);
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        bit         s;
        logic [7:0] r;
    } vec4_t;

    task automatic test_products4();
        vec4_t tbl[9];
        int c, bc;
        tbl = '{'{4'd3, 4'd5, 1'b0, 8'h0F}, '{4'hF, 4'hF, 1'b0, 8'hE1}, '{4'hD, 4'd5, 1'b1, 8'hF1},
                '{4'h8, 4'h8, 1'b1, 8'h40}, '{4'h8, 4'd7, 1'b1, 8'hC8}, '{4'd0, 4'd9, 1'b0, 8'h00},
                '{4'd7, 4'd0, 1'b1, 8'h00}, '{4'hF, 4'hF, 1'b1, 8'h01}, '{4'd7, 4'h8, 1'b1, 8'hC8}};
        foreach (tbl[i]) begin
            launch4(tbl[i].a, tbl[i].b, tbl[i].s, 1'b1);
            wait_done4(c, bc);
            checks++;
            if (c !== 5 || bc !== 4) begin
                errors++;
                $display("FAIL latency4[%0d]: cycles=%0d busy=%0d required 5 4", i, c, bc);
            end
            checks++;
            if (r4 !== tbl[i].r) begin
                errors++;
                $display("FAIL product4[%0d]: r=%h required %h", i, r4, tbl[i].r);
            end
        end
    endtask

    task automatic test_ignore_start();
        int c, bc;
        launch4(4'd3, 4'd5, 1'b0, 1'b1);
        @(negedge clk);
        a4 = 4'd9; b4 = 4'd9; sm4 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; a4 = 4'hF; b4 = 4'h1;
        wait_done4(c, bc);
        checks++;
        if (c !== 3 || r4 !== 8'h0F) begin
            errors++;
            $display("FAIL ignore_start: cycles=%0d r=%h required 3 0f", c, r4);
        end
    endtask

    task automatic test_back_to_back();
        int c, bc;
        launch4(4'd2, 4'd3, 1'b0, 1'b1);
        wait_done4(c, bc);
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done_cycle: busy=%b done=%b required 0 1", busy4, done4);
        end
        launch4(4'd5, 4'd6, 1'b0, 1'b1);
        wait_done4(c, bc);
        checks++;
        if (c !== 5 || r4 !== 8'h1E) begin
            errors++;
            $display("FAIL b2b_second: cycles=%0d r=%h required 5 1e", c, r4);
        end
    endtask

    task automatic test_abort();
        int c, bc, seen;
        launch4(4'd7, 4'd3, 1'b0, 1'b0);
        @(negedge clk); start4 = 1'b0;
        @(negedge clk); abort4 = 1'b1;
        @(negedge clk); abort4 = 1'b0;
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || r4 !== 8'h1E) begin
            errors++;
            $display("FAIL abort_mid: busy=%b done=%b r=%h required 0 0 1e", busy4, done4, r4);
        end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done4) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done: done pulses=%0d required 0", seen);
        end
        launch4(4'd7, 4'd3, 1'b0, 1'b0);
        @(negedge clk); start4 = 1'b0;
        repeat (3) @(negedge clk);
        abort4 = 1'b1;
        @(negedge clk); abort4 = 1'b0;
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || r4 !== 8'h1E) begin
            errors++;
            $display("FAIL abort_last: busy=%b done=%b r=%h required 0 0 1e", busy4, done4, r4);
        end
        abort4 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy4 !== 1'b0 || r4 !== 8'h1E) begin
            errors++;
            $display("FAIL abort_idle: busy=%b r=%h required 0 1e", busy4, r4);
        end
        launch4(4'd2, 4'd2, 1'b0, 1'b1);
        @(negedge clk); abort4 = 1'b0; start4 = 1'b0;
        wait_done4(c, bc);
        checks++;
        if (c !== 4 || r4 !== 8'h04) begin
            errors++;
            $display("FAIL abort_start_idle: cycles=%0d r=%h required 4 04", c, r4);
        end
    endtask

    task automatic test_n8();
        int c;
        launch8(8'hFF, 8'hFF, 1'b0, 1'b1);
        wait_done8(c);
        checks++;
        if (c !== 9 || r8 !== 16'hFE01) begin
            errors++;
            $display("FAIL n8_umax: cycles=%0d r=%h required 9 fe01", c, r8);
        end
        launch8(8'h80, 8'h7F, 1'b1, 1'b1);
        wait_done8(c);
        checks++;
        if (c !== 9 || r8 !== 16'hC080) begin
            errors++;
            $display("FAIL n8_smin: cycles=%0d r=%h required 9 c080", c, r8);
        end
        for (int i = 0; i < 1000; i++) begin
            launch8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            wait_done8(c);
            checks++;
            if (c !== 9) begin
                errors++;
                $display("FAIL n8_random_latency[%0d]: cycles=%0d required 9", i, c);
            end
        end
    endtask

    task automatic test_async_reset();
        launch4(4'd9, 4'd9, 1'b0, 1'b0);
        @(negedge clk); start4 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy4, done4, r4} !== 10'b0 || r8 !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b r4=%h r8=%h required 0 0 00 0000",
                     busy4, done4, r4, r8);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (busy4 !== 1'b0 || r4 !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b r=%h required 0 00", busy4, r4);
        end
    endtask

    initial begin
        test_reset();
        test_products4();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_n8();
        test_async_reset();
        checks++;
        if (q4.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending4=%0d pending8=%0d required 0 0", q4.size(), q8.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
